// File: rtl/risc_pkg.sv
// Shared definitions for the instruction-fetch side of the RISC core:
// datapath widths, reset/halt constants and the fetch FSM state type.
package risc_pkg;

    localparam int INSTR_W  = 32;
    localparam int ADDR_W   = 32;
    localparam int OPCODE_W = 6;

    localparam logic [ADDR_W-1:0]   RESET_PC    = 32'h0000_0000;
    localparam logic [OPCODE_W-1:0] HALT_OPCODE = 6'b111111;

    // Word-aligned addresses: the two low byte-offset bits are always zero.
    localparam logic [ADDR_W-1:0]   ADDR_MASK   = 32'hFFFF_FFFC;

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        WAIT   = 2'd1,
        ISSUE  = 2'd2,
        HALTED = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: requests one word per instruction from instruction
// memory, holds it for decode until accepted, then advances the PC sequentially
// or to a redirect target. A HALT opcode parks the unit until reset.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC    = risc_pkg::RESET_PC,
    parameter logic [5:0]  HALT_OPCODE = risc_pkg::HALT_OPCODE
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imemReq,
    output logic [31:0] imemAddr,
    input  logic        imemValid,
    input  logic [31:0] imemData,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirectTarget,
    output logic [31:0] instr,
    output logic [5:0]  opcode,
    output logic [31:0] pcOut,
    output logic [31:0] pcPlus4,
    output logic        instrValid,
    output logic        halted
);

    import risc_pkg::*;

    localparam logic [ADDR_W-1:0] START_PC = RESET_PC & ADDR_MASK;

    fetch_state_t          state_q, state_d;
    logic [ADDR_W-1:0]     pc_q, pc_d;
    logic [ADDR_W-1:0]     pc_out_q, pc_out_d;
    logic [INSTR_W-1:0]    instr_q, instr_d;
    logic                  halted_q, halted_d;
    // Cleared by reset so the first request appears only once reset has been
    // released, without a combinational path from rst to imemReq.
    logic                  active_q;
    logic [ADDR_W-1:0]     pc_incr;
    logic [OPCODE_W-1:0]   cur_opcode;

    // Single incrementer serves both the sequential next PC and the link value.
    assign pc_incr    = pc_out_q + 32'd4;
    assign cur_opcode = instr_q[INSTR_W-1:INSTR_W-OPCODE_W];

    // Next-state and datapath update decisions for the fetch sequence.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        pc_out_d = pc_out_q;
        instr_d  = instr_q;
        halted_d = halted_q;
        case (state_q)
            FETCH: begin
                if (active_q) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (imemValid) begin
                    instr_d  = imemData;
                    pc_out_d = pc_q;
                    state_d  = ISSUE;
                end
            end
            ISSUE: begin
                if (!stall) begin
                    if (cur_opcode == HALT_OPCODE) begin
                        state_d  = HALTED;
                        halted_d = 1'b1;
                    end else begin
                        state_d = FETCH;
                        if (redirect) begin
                            pc_d = redirectTarget & ADDR_MASK;
                        end else begin
                            pc_d = pc_incr & ADDR_MASK;
                        end
                    end
                end
            end
            HALTED: begin
                state_d = HALTED;
            end
            default: begin
                state_d = FETCH;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= FETCH;
            pc_q     <= START_PC;
            pc_out_q <= START_PC;
            instr_q  <= '0;
            halted_q <= 1'b0;
            active_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            pc_out_q <= pc_out_d;
            instr_q  <= instr_d;
            halted_q <= halted_d;
            active_q <= 1'b1;
        end
    end

    assign imemReq    = (state_q == FETCH) && active_q;
    assign imemAddr   = pc_q;
    assign instr      = instr_q;
    assign opcode     = cur_opcode;
    assign pcOut      = pc_out_q;
    assign pcPlus4    = pc_incr;
    assign instrValid = (state_q == ISSUE);
    assign halted     = halted_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed vector table, hand-written
// halt/wrap/reset sequences, and randomized transactions against a
// transaction-level model of the PC sequence.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        imemReq;
    logic [31:0] imemAddr;
    logic        imemValid = 1'b0;
    logic [31:0] imemData = '0;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirectTarget = '0;
    logic [31:0] instr;
    logic [5:0]  opcode;
    logic [31:0] pcOut;
    logic [31:0] pcPlus4;
    logic        instrValid;
    logic        halted;

    int n_checks = 0;
    int n_fail   = 0;
    int cycle    = 0;
    int issue_cycle = 0;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam logic [5:0]  HALT_OP = 6'b111111;

    instr_fetch_unit dut (
        .clk(clk), .rst(rst),
        .imemReq(imemReq), .imemAddr(imemAddr),
        .imemValid(imemValid), .imemData(imemData),
        .stall(stall), .redirect(redirect), .redirectTarget(redirectTarget),
        .instr(instr), .opcode(opcode), .pcOut(pcOut), .pcPlus4(pcPlus4),
        .instrValid(instrValid), .halted(halted)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Cycle counter used for latency and throughput measurements.
    always @(posedge clk) cycle <= cycle + 1;

    typedef struct {
        int          lat;
        int          stall_cycles;
        bit          redir;
        logic [31:0] target;
        logic [31:0] data;
        logic [31:0] exp_addr;
    } vec_t;

    vec_t vecs[6];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    // One full fetch/issue/accept transaction; next_addr is the model's
    // prediction of the following fetch address.
    task automatic apply_stimulus(input int lat, input int stall_cycles, input bit redir,
                                  input logic [31:0] target, input logic [31:0] data,
                                  input logic [31:0] exp_addr, output logic [31:0] next_addr);
        int  n;
        bit  is_halt;
        n = 0;
        while (!imemReq && n < 8) begin
            tick();
            n++;
        end
        check_output("req_seen", imemReq, 1'b1);
        check_output("fetch_addr", imemAddr, exp_addr);
        check_output("fetch_valid_low", instrValid, 1'b0);
        tick();
        for (int i = 0; i <= lat; i++) begin
            check_output("wait_req_low", imemReq, 1'b0);
            check_output("wait_addr_stable", imemAddr, exp_addr);
            check_output("wait_valid_low", instrValid, 1'b0);
            if (i == lat) begin
                imemValid = 1'b1;
                imemData  = data;
                redirect  = 1'b0;
            end else begin
                redirect       = 1'($urandom_range(0, 1));
                redirectTarget = $urandom;
            end
            tick();
        end
        imemValid = 1'b0;
        redirect  = 1'b0;
        issue_cycle = cycle;
        check_output("issue_valid", instrValid, 1'b1);
        check_output("issue_instr", instr, data);
        check_output("issue_opcode", {26'b0, opcode}, {26'b0, data[31:26]});
        check_output("issue_pc", pcOut, exp_addr);
        check_output("issue_pc4", pcPlus4, exp_addr + 32'd4);
        check_output("issue_req_low", imemReq, 1'b0);
        for (int i = 0; i < stall_cycles; i++) begin
            stall          = 1'b1;
            redirect       = 1'b1;
            redirectTarget = $urandom;
            imemValid      = (i % 2 == 0);
            imemData       = 32'hDEAD_0000 | i;
            tick();
            check_output("stall_valid", instrValid, 1'b1);
            check_output("stall_instr", instr, data);
            check_output("stall_pc", pcOut, exp_addr);
            check_output("stall_req_low", imemReq, 1'b0);
        end
        imemValid      = 1'b0;
        stall          = 1'b0;
        redirect       = redir;
        redirectTarget = target;
        tick();
        redirect = 1'b0;
        is_halt  = (data[31:26] == HALT_OP);
        if (is_halt)
            next_addr = exp_addr;
        else if (redir)
            next_addr = {target[31:2], 2'b00};
        else
            next_addr = exp_addr + 32'd4;
        check_output("post_accept_valid_low", instrValid, 1'b0);
        check_output("post_accept_halted", halted, is_halt);
    endtask

    initial begin
        logic [31:0] addr;
        logic [31:0] nxt;
        int release_cycle;
        int issue0, issue1, issue2;
        bit saw_req;

        vecs[0] = '{0, 0, 1'b0, 32'h0,         32'h0000_0000, 32'h0000_0000};
        vecs[1] = '{0, 0, 1'b0, 32'h0,         32'h0000_0001, 32'h0000_0004};
        vecs[2] = '{0, 4, 1'b0, 32'h0,         32'h1234_5678, 32'h0000_0008};
        vecs[3] = '{5, 0, 1'b0, 32'h0,         32'h0000_0003, 32'h0000_000C};
        vecs[4] = '{2, 2, 1'b1, 32'h0000_0103, 32'h0400_0004, 32'h0000_0010};
        vecs[5] = '{1, 0, 1'b0, 32'h0,         32'h0800_0005, 32'h0000_0100};

        // Reset state
        tick();
        tick();
        tick();
        check_output("rst_req", imemReq, 1'b0);
        check_output("rst_valid", instrValid, 1'b0);
        check_output("rst_halted", halted, 1'b0);
        check_output("rst_opcode", {26'b0, opcode}, 32'h0);
        check_output("rst_instr", instr, 32'h0);
        check_output("rst_pcout", pcOut, RST_PC);
        check_output("rst_pc4", pcPlus4, RST_PC + 32'd4);
        rst = 1'b1;
        release_cycle = cycle;

        // Directed vector table
        issue0 = 0; issue1 = 0; issue2 = 0;
        for (int v = 0; v < 6; v++) begin
            apply_stimulus(vecs[v].lat, vecs[v].stall_cycles, vecs[v].redir,
                           vecs[v].target, vecs[v].data, vecs[v].exp_addr, nxt);
            if (v == 0) issue0 = issue_cycle;
            if (v == 1) issue1 = issue_cycle;
            if (v == 2) issue2 = issue_cycle;
        end
        check_output("first_valid_latency", issue0 - release_cycle, 3);
        check_output("period_0_1", issue1 - issue0, 3);
        check_output("period_1_2", issue2 - issue1, 3);
        check_output("after_table_addr", imemAddr, 32'h0000_0104);

        // Halt with redirect asserted: redirect ignored, unit parks
        apply_stimulus(0, 1, 1'b1, 32'h0000_0500, {HALT_OP, 26'h0000ABC}, 32'h0000_0104, nxt);
        check_output("halt_pc_held", imemAddr, 32'h0000_0104);
        saw_req = 1'b0;
        for (int i = 0; i < 20; i++) begin
            imemValid = (i % 3 == 0);
            imemData  = $urandom;
            tick();
            if (imemReq) saw_req = 1'b1;
        end
        imemValid = 1'b0;
        check_output("halt_no_req", saw_req, 1'b0);
        check_output("halt_sticky", halted, 1'b1);
        check_output("halt_valid_low", instrValid, 1'b0);
        rst = 1'b0;
        tick();
        check_output("halt_rst_clear", halted, 1'b0);
        rst = 1'b1;

        // Refetch from reset PC, then redirect to the top of memory and wrap
        apply_stimulus(0, 0, 1'b1, 32'hFFFF_FFFF, 32'h0C00_0001, RST_PC, nxt);
        apply_stimulus(1, 0, 1'b0, 32'h0, 32'h1000_0002, nxt, addr);
        check_output("wrap_addr", addr, 32'h0);
        check_output("wrap_imem_addr", imemAddr, 32'h0);

        // Reset during WAIT with a stray response right after release
        tick();
        check_output("midwait_req_low", imemReq, 1'b0);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        check_output("midwait_rst_req", imemReq, 1'b0);
        check_output("midwait_rst_pc", pcOut, RST_PC);
        tick();
        imemValid = 1'b1;
        imemData  = 32'hBAD0_BAD0;
        check_output("midwait_refetch_req", imemReq, 1'b1);
        check_output("midwait_refetch_addr", imemAddr, RST_PC);
        tick();
        imemValid = 1'b0;
        check_output("midwait_stray_ignored", instrValid, 1'b0);
        tick();
        check_output("midwait_still_waiting", instrValid, 1'b0);
        imemValid = 1'b1;
        imemData  = 32'h1400_0007;
        tick();
        imemValid = 1'b0;
        check_output("midwait_good_valid", instrValid, 1'b1);
        check_output("midwait_good_instr", instr, 32'h1400_0007);
        check_output("midwait_good_pc", pcOut, RST_PC);
        tick();
        addr = RST_PC + 32'd4;

        // Randomized transactions against the PC-sequence model
        for (int t = 0; t < 40; t++) begin
            logic [31:0] data;
            logic [31:0] tgt;
            bit          rd;
            data = $urandom;
            if (data[31:26] == HALT_OP) data[31] = 1'b0;
            tgt = $urandom;
            rd  = ($urandom_range(0, 3) == 0);
            apply_stimulus(int'($urandom_range(0, 4)), int'($urandom_range(0, 3)),
                           rd, tgt, data, addr, nxt);
            addr = nxt;
        end
        check_output("final_addr", imemAddr, addr);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
